// File: rtl/keypad_scanner.sv
// Scanned, debounced 4x3 membrane keypad: one-hot row drive, column sampling, one strobe per press.
// Define KEYPAD_REPEAT_EN to re-strobe key_valid every REPEAT_TICKS ticks while a key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV     = 208_333,
    parameter int DEBOUNCE_N   = 4,
    parameter int REPEAT_TICKS = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:2] pad,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [1:0] S_SCAN = 2'd0, S_DEB = 2'd1, S_HELD = 2'd2, S_REL = 2'd3;
    localparam logic [3:0] IDLE_CODE = 4'd12;

    logic [2:0]    sync_q, col_q;
    logic [DW-1:0] div_q;
    logic [1:0]    state_q, state_d;
    logic [3:0]    row_q, row_d, code_q, code_d;
    logic [2:0]    lcol_q, lcol_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          valid_q, valid_d, held_q, held_d;
    logic          tick, col_ok, acc, rel;
    logic [1:0]    ridx, cidx;
    logic [3:0]    code_calc, row_rot;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] rep_q, rep_d, rep_inc;
`endif

    assign tick    = (div_q == DW'(SCAN_DIV - 1));
    assign col_ok  = (col_q != 3'b000) && ((col_q & (col_q - 3'b001)) == 3'b000);
    assign cnt_inc = cnt_q + CW'(1);
    assign row_rot = {row_q[2:0], row_q[3]};

    always_comb begin
        ridx = 2'd0;
        case (row_q)
            4'b0010: ridx = 2'd1;
            4'b0100: ridx = 2'd2;
            4'b1000: ridx = 2'd3;
            default: ridx = 2'd0;
        endcase
        cidx = col_q[2] ? 2'd2 : (col_q[1] ? 2'd1 : 2'd0);
        if (ridx == 2'd3)
            code_calc = (cidx == 2'd0) ? 4'd10 : ((cidx == 2'd1) ? 4'd0 : 4'd11);
        else
            code_calc = {2'b00, ridx} * 4'd3 + {2'b00, cidx} + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        code_d  = code_q;
        lcol_d  = lcol_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        valid_d = 1'b0;
        acc     = 1'b0;
        rel     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
        rep_inc = rep_q + RW'(1);
`endif
        if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (col_ok) begin
                        lcol_d = col_q;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_N == 1) acc = 1'b1;
                        else state_d = S_DEB;
                    end else begin
                        row_d = row_rot;
                    end
                end
                S_DEB: begin
                    if (col_q == lcol_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_N)) acc = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                        row_d   = row_rot;
                    end
                end
                S_HELD: begin
                    // Any non-zero column keeps the original key; first key wins.
                    if (col_q == 3'b000) begin
                        cnt_d = CW'(1);
`ifdef KEYPAD_REPEAT_EN
                        rep_d = '0;
`endif
                        if (DEBOUNCE_N == 1) rel = 1'b1;
                        else state_d = S_REL;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_inc == RW'(REPEAT_TICKS)) begin
                        rep_d   = '0;
                        valid_d = 1'b1;
                    end else begin
                        rep_d = rep_inc;
                    end
`endif
                end
                default: begin
                    if (col_q == 3'b000) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_N)) rel = 1'b1;
                    end else begin
                        state_d = S_HELD;
                    end
                end
            endcase
        end
        if (acc) begin
            code_d  = code_calc;
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = S_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
        end
        if (rel) begin
            code_d  = IDLE_CODE;
            held_d  = 1'b0;
            state_d = S_SCAN;
            row_d   = row_rot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 3'b000;
            col_q   <= 3'b000;
            div_q   <= '0;
            state_q <= S_SCAN;
            row_q   <= 4'b0001;
            code_q  <= IDLE_CODE;
            lcol_q  <= 3'b000;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            sync_q  <= {pad[2], pad[1], pad[0]};
            col_q   <= sync_q;
            div_q   <= tick ? '0 : div_q + DW'(1);
            state_q <= state_d;
            row_q   <= row_d;
            code_q  <= code_d;
            lcol_q  <= lcol_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign row       = row_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
endmodule
